rf_wb_arbiter: RTL

Writeback arbiter for the 6-read/3-write integer register file. It accepts register writebacks from N_REQ functional-unit requesters over valid/ready handshakes and grants at most three per cycle using rotating priority. It drives the file's three write ports (wen/wrptr/wr) from registers. Writes to register 0 are absorbed without using a port, and two same-cycle writes to one register are serialized.

---
 rtl/rf_wb_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: grants up to three register-file writes per cycle with rotating priority.
// Optional RF_WB_PERF_EN adds stall_cycles and drop_x0 performance counters.
module rf_wb_arbiter #(
  parameter int WIDTH    = 64,
  parameter int LG_DEPTH = 6,
  parameter int N_REQ    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*LG_DEPTH-1:0] req_ptr,
  input  logic [N_REQ*WIDTH-1:0]    req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      wen0,
  output logic                      wen1,
  output logic                      wen2,
  output logic [LG_DEPTH-1:0]       wrptr0,
  output logic [LG_DEPTH-1:0]       wrptr1,
  output logic [LG_DEPTH-1:0]       wrptr2,
  output logic [WIDTH-1:0]          wr0,
  output logic [WIDTH-1:0]          wr1,
  output logic [WIDTH-1:0]          wr2
`ifdef RF_WB_PERF_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               drop_x0
`endif
);

  localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [LG_DEPTH-1:0] ptr_a [N_REQ];
  logic [WIDTH-1:0]    data_a [N_REQ];

  logic [RR_W-1:0]     rr_q, rr_d;
  logic [2:0]          wen_q, wen_d;
  logic [LG_DEPTH-1:0] wrptr_q [3];
  logic [LG_DEPTH-1:0] wrptr_d [3];
  logic [WIDTH-1:0]    wr_q [3];
  logic [WIDTH-1:0]    wr_d [3];

  logic [N_REQ-1:0]    ready_c;
  logic [N_REQ-1:0]    x0_c;
  logic [RR_W-1:0]     idx;
  logic [1:0]          nports;
  logic                dup;
  logic [LG_DEPTH-1:0] cur_ptr;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign ptr_a[g]  = req_ptr[g*LG_DEPTH +: LG_DEPTH];
    assign data_a[g] = req_data[g*WIDTH +: WIDTH];
  end

  function automatic logic [RR_W-1:0] inc_wrap(input logic [RR_W-1:0] i);
    if (i == RR_W'(N_REQ - 1)) begin
      return '0;
    end
    return i + 1'b1;
  endfunction

  function automatic logic [31:0] popcnt(input logic [N_REQ-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < N_REQ; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

  // Rotating scan: x0 writes are absorbed freely, others take ports in scan order
  always_comb begin
    ready_c = '0;
    x0_c    = '0;
    rr_d    = rr_q;
    wen_d   = '0;
    for (int p = 0; p < 3; p++) begin
      wrptr_d[p] = wrptr_q[p];
      wr_d[p]    = wr_q[p];
    end
    idx     = rr_q;
    nports  = '0;
    dup     = 1'b0;
    cur_ptr = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cur_ptr = ptr_a[idx];
      if (req_valid[idx]) begin
        if (cur_ptr == '0) begin
          ready_c[idx] = 1'b1;
          x0_c[idx]    = 1'b1;
        end else if (nports != 2'd3) begin
          dup = 1'b0;
          for (int p = 0; p < 3; p++) begin
            if (wen_d[p] && (wrptr_d[p] == cur_ptr)) begin
              dup = 1'b1;
            end
          end
          if (!dup) begin
            ready_c[idx]    = 1'b1;
            wen_d[nports]   = 1'b1;
            wrptr_d[nports] = cur_ptr;
            wr_d[nports]    = data_a[idx];
            nports          = nports + 2'd1;
            rr_d            = inc_wrap(idx);
          end
        end
      end
      idx = inc_wrap(idx);
    end
  end

  assign req_ready = reset ? '0 : ready_c;

  // Write-port stage: grants from cycle t drive the register file during t+1
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q  <= '0;
      wen_q <= '0;
      for (int p = 0; p < 3; p++) begin
        wrptr_q[p] <= '0;
        wr_q[p]    <= '0;
      end
    end else begin
      rr_q  <= rr_d;
      wen_q <= wen_d;
      for (int p = 0; p < 3; p++) begin
        wrptr_q[p] <= wrptr_d[p];
        wr_q[p]    <= wr_d[p];
      end
    end
  end

  assign wen0   = wen_q[0];
  assign wen1   = wen_q[1];
  assign wen2   = wen_q[2];
  assign wrptr0 = wrptr_q[0];
  assign wrptr1 = wrptr_q[1];
  assign wrptr2 = wrptr_q[2];
  assign wr0    = wr_q[0];
  assign wr1    = wr_q[1];
  assign wr2    = wr_q[2];

`ifdef RF_WB_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] drop_q, drop_d;

  always_comb begin
    stall_d = stall_q + 32'(|(req_valid & ~req_ready));
    drop_d  = drop_q + popcnt(x0_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      drop_q  <= '0;
    end else begin
      stall_q <= stall_d;
      drop_q  <= drop_d;
    end
  end

  assign stall_cycles = stall_q;
  assign drop_x0      = drop_q;
`else
  logic unused_perf;
  assign unused_perf = ^popcnt(x0_c);
`endif

endmodule
